aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_rcon_gen.sv | 23 ++
 rtl/aes_round_sequencer.sv | 140 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// The state enum, the round-constant seeds and the xtime helper live here.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic [7:0] RCON_INIT     = 8'h01;
  localparam logic [7:0] RCON_POLY     = 8'h1B;
  localparam int         AES128_ROUNDS = 10;

  // Multiply by x in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for AES key expansion.
// load returns the register to the first-round constant; step advances it by one round.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [7:0] rcon
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rcon <= RCON_INIT;
    end else if (load) begin
      rcon <= RCON_INIT;
    end else if (step) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences the rounds of one AES-128 block through an external round datapath.
// Each round is issued, then the sequencer waits for the datapath return, guarded by a watchdog.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ROUNDS = AES128_ROUNDS,
  parameter int TMO    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       rnd_issue,
  output logic       rnd_empty,
  output logic       rnd_first,
  output logic       rnd_final,
  output logic [7:0] rnd_rcon,
  input  logic       rnd_ret,
  output logic [3:0] round,
  output logic       out_capture,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_valid/in_ready accept a block only in IDLE; out_valid/out_ready release it from DONE.

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
  localparam logic [7:0] WD_LOAD    = 8'(LAT + TMO);

  seq_state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;
  logic       cap_q, cap_d;
  logic       rc_load, rc_step;
  logic [7:0] rcon;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    cap_d   = 1'b0;
    rc_load = 1'b0;
    rc_step = 1'b0;
    // A datapath return is only meaningful while a round is outstanding.
    if (rnd_ret && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        round_d = 4'd0;
        wdog_d  = 8'd0;
        rc_load = 1'b1;
        if (in_valid) begin
          state_d = ST_ISSUE;
          round_d = 4'd1;
          wdog_d  = WD_LOAD;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wdog_d  = wdog_q - 8'd1;
      end
      ST_WAIT: begin
        wdog_d = wdog_q - 8'd1;
        if (rnd_ret) begin
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
            cap_d   = 1'b1;
            wdog_d  = 8'd0;
          end else begin
            state_d = ST_ISSUE;
            round_d = round_q + 4'd1;
            rc_step = 1'b1;
            wdog_d  = WD_LOAD;
          end
        end else if (wdog_q <= 8'd1) begin
          // Watchdog expiry drops the block.
          state_d = ST_IDLE;
          err_d   = 1'b1;
          round_d = 4'd0;
          wdog_d  = 8'd0;
          rc_load = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          round_d = 4'd0;
          rc_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  aes_rcon_gen u_rcon (
    .clock (clock),
    .reset (reset),
    .load  (rc_load),
    .step  (rc_step),
    .rcon  (rcon)
  );

  assign in_ready    = (state_q == ST_IDLE);
  assign rnd_issue   = (state_q == ST_ISSUE);
  assign rnd_empty   = ~rnd_issue;
  assign rnd_first   = rnd_issue && (round_q == 4'd1);
  assign rnd_final   = rnd_issue && (round_q == LAST_ROUND);
  assign rnd_rcon    = rcon;
  assign round       = round_q;
  assign out_capture = cap_q;
  assign out_valid   = (state_q == ST_DONE);
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a delay-line datapath model plus timing/rcon expectations
// derived from the round schedule (issue k at T+1+(k-1)*(LAT+1), result at T+1+ROUNDS*(LAT+1)).
module tb_aes_round_sequencer;

  localparam int LAT    = 2;
  localparam int ROUNDS = 10;
  localparam int TMO    = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       rnd_issue;
  logic       rnd_empty;
  logic       rnd_first;
  logic       rnd_final;
  logic [7:0] rnd_rcon;
  logic       rnd_ret;
  logic [3:0] round;
  logic       out_capture;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int drop_round = -1;
  int ret_q[$];
  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes_round_sequencer #(.LAT(LAT), .ROUNDS(ROUNDS), .TMO(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rnd_issue   (rnd_issue),
    .rnd_empty   (rnd_empty),
    .rnd_first   (rnd_first),
    .rnd_final   (rnd_final),
    .rnd_rcon    (rnd_rcon),
    .rnd_ret     (rnd_ret),
    .round       (round),
    .out_capture (out_capture),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, then advance the datapath model.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (rnd_issue && (int'(round) != drop_round)) ret_q.push_back(cyc + LAT);
    rnd_ret = (ret_q.size() > 0) && (ret_q[0] == cyc);
    if (rnd_ret) void'(ret_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rnd_ret = 1'b0;
    ret_q.delete();
    drop_round = -1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_issue"}, rnd_issue, 1'b0);
    check({tag, "_empty"}, rnd_empty, 1'b1);
    check({tag, "_first"}, rnd_first, 1'b0);
    check({tag, "_final"}, rnd_final, 1'b0);
    check({tag, "_rcon"}, rnd_rcon, 8'h01);
    check({tag, "_round"}, round, 4'd0);
    check({tag, "_capture"}, out_capture, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  // Runs one block from IDLE to the output handshake; hold keeps in_valid high throughout.
  task automatic run_block(input int bp, input bit hold);
    int t;
    int k;
    bit done;
    check("accept_ready", in_ready, 1'b1);
    check("idle_no_issue", rnd_issue, 1'b0);
    in_valid = 1'b1;
    t = cyc;
    tick();
    if (!hold) in_valid = 1'b0;
    k = 0;
    done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      if (rnd_issue) begin
        k++;
        check("issue_cycle", cyc, t + 1 + (k - 1) * (LAT + 1));
        check("issue_round", round, k);
        if (k >= 1 && k <= 10) check("issue_rcon", rnd_rcon, rcon_tab[k-1]);
        check("issue_first", rnd_first, (k == 1));
        check("issue_final", rnd_final, (k == ROUNDS));
      end
      check("empty_vs_issue", rnd_empty, !rnd_issue);
      if (out_valid) done = 1'b1;
      else tick();
    end
    check("done_reached", out_valid, 1'b1);
    check("out_latency", cyc, t + 1 + ROUNDS * (LAT + 1));
    check("capture_pulse", out_capture, 1'b1);
    check("round_count", k, ROUNDS);
    check("busy_not_ready", in_ready, 1'b0);
    out_ready = 1'b0;
    repeat (bp) begin
      tick();
      check("bp_valid_held", out_valid, 1'b1);
      check("bp_not_ready", in_ready, 1'b0);
      check("bp_capture_low", out_capture, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_ready", in_ready, 1'b1);
    check("post_hs_valid", out_valid, 1'b0);
    check("post_hs_round", round, 4'd0);
    check("post_hs_rcon", rnd_rcon, 8'h01);
  endtask

  task automatic run_watchdog();
    int g;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drop_round = 4;
    g = 0;
    while (!(rnd_issue && round == 4'd4) && g < 100) begin
      tick();
      g++;
    end
    check("wd_round4_issued", round, 4'd4);
    repeat (LAT + TMO - 1) begin
      tick();
      check("wd_err_early", err, 1'b0);
      check("wd_busy", in_ready, 1'b0);
    end
    tick();
    check("wd_err", err, 1'b1);
    check("wd_idle_ready", in_ready, 1'b1);
    check("wd_round0", round, 4'd0);
    check("wd_no_issue", rnd_issue, 1'b0);
    tick();
    check("wd_err_sticky", err, 1'b1);
    check("wd_no_issue2", rnd_issue, 1'b0);
    drop_round = -1;
  endtask

  task automatic run_spurious();
    check("sp_err_before", err, 1'b0);
    rnd_ret = 1'b1;
    tick();
    check("sp_err", err, 1'b1);
    check("sp_no_issue", rnd_issue, 1'b0);
    check("sp_ready", in_ready, 1'b1);
    tick();
    check("sp_no_issue2", rnd_issue, 1'b0);
    check("sp_err_sticky", err, 1'b1);
  endtask

  task automatic run_mid_reset();
    int g;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    g = 0;
    while (!(rnd_issue && round == 4'd6) && g < 100) begin
      tick();
      g++;
    end
    check("mr_round6_issued", round, 4'd6);
    tick();
    check("mr_in_wait", in_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mr");
    ret_q.delete();
    rnd_ret = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_block(1, 1'b0);
    check("mr_err_clear", err, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rnd_ret = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    run_block(0, 1'b0);
    run_block(5, 1'b0);
    run_block(0, 1'b1);
    run_block(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_block($urandom_range(0, 6), 1'b0);
    end
    check("no_err_after_traffic", err, 1'b0);

    run_watchdog();
    do_reset();
    run_spurious();
    do_reset();
    run_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
